// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush sequencer
// Handles redirects, load-use hazards, multi-cycle mul/div occupancy and debug parking.
module pipe_ctrl #(
   parameter int MULDIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       debug,
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       ID_use_rs,
   input  logic       ID_use_rt,
   input  logic       EX_mem_read,
   input  logic [4:0] EX_rf_waddr,
   input  logic       EX_muldiv,
   input  logic       ME_pc_control,
   output logic       pc_stall,
   output logic       pc_init,
   output logic       if_id_stall,
   output logic       id_ex_stall,
   output logic       ex_me_stall,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       ex_me_flush,
   output logic       me_wb_flush,
   output logic       muldiv_busy,
   output logic       muldiv_done
);

   typedef enum logic [1:0] {RUN, MULDIV, DEBUG, RESUME} state_t;

   localparam logic [5:0] CNT_INIT = 6'(MULDIV_CYCLES - 2);

   state_t     state, state_nxt;
   logic [5:0] cnt, cnt_nxt;
   logic       load_use;

   // $0 is hardwired zero, so writing it never creates a dependency
   assign load_use = EX_mem_read && (EX_rf_waddr != 5'd0) &&
                     ((ID_use_rs && (ID_rs == EX_rf_waddr)) ||
                      (ID_use_rt && (ID_rt == EX_rf_waddr)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= 6'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pc_stall    = 1'b0;
      pc_init     = 1'b0;
      if_id_stall = 1'b0;
      id_ex_stall = 1'b0;
      ex_me_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_me_flush = 1'b0;
      me_wb_flush = 1'b0;
      muldiv_busy = 1'b0;
      muldiv_done = 1'b0;

      if (reset) begin
         state_nxt   = RUN;
         cnt_nxt     = 6'd0;
         pc_init     = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         ex_me_flush = 1'b1;
         me_wb_flush = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (ME_pc_control) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  ex_me_flush = 1'b1;
               end else if (EX_muldiv) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_stall = 1'b1;
                  ex_me_flush = 1'b1;
                  state_nxt   = MULDIV;
                  cnt_nxt     = CNT_INIT;
               end else if (load_use) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
            end
            MULDIV: begin
               muldiv_busy = 1'b1;
               if (cnt == 6'd0) begin
                  // a final cycle cut short by debug counts as abandoned
                  muldiv_done = !debug;
                  state_nxt   = RUN;
               end else begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_stall = 1'b1;
                  ex_me_flush = 1'b1;
                  cnt_nxt     = cnt - 6'd1;
               end
            end
            DEBUG: begin
               pc_stall    = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               ex_me_flush = 1'b1;
               me_wb_flush = 1'b1;
               if (!debug) state_nxt = RESUME;
            end
            RESUME: begin
               pc_init     = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               ex_me_flush = 1'b1;
               me_wb_flush = 1'b1;
               state_nxt   = RUN;
            end
            default: state_nxt = RUN;
         endcase

         if (debug) begin
            state_nxt = DEBUG;
            cnt_nxt   = 6'd0;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed checks of pipe_ctrl with MULDIV_CYCLES=4
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       reset, debug;
   logic [4:0] ID_rs, ID_rt, EX_rf_waddr;
   logic       ID_use_rs, ID_use_rt, EX_mem_read, EX_muldiv, ME_pc_control;
   logic       pc_stall, pc_init, if_id_stall, id_ex_stall, ex_me_stall;
   logic       if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush;
   logic       muldiv_busy, muldiv_done;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [10:0] B_PC_STALL = 11'b100_0000_0000;
   localparam logic [10:0] B_PC_INIT  = 11'b010_0000_0000;
   localparam logic [10:0] B_IF_STALL = 11'b001_0000_0000;
   localparam logic [10:0] B_ID_STALL = 11'b000_1000_0000;
   localparam logic [10:0] B_IF_FLUSH = 11'b000_0010_0000;
   localparam logic [10:0] B_ID_FLUSH = 11'b000_0001_0000;
   localparam logic [10:0] B_EX_FLUSH = 11'b000_0000_1000;
   localparam logic [10:0] B_ME_FLUSH = 11'b000_0000_0100;
   localparam logic [10:0] B_BUSY     = 11'b000_0000_0010;
   localparam logic [10:0] B_DONE     = 11'b000_0000_0001;

   localparam logic [10:0] E_QUIET = 11'd0;
   localparam logic [10:0] E_ALLFL = B_IF_FLUSH | B_ID_FLUSH | B_EX_FLUSH | B_ME_FLUSH;
   localparam logic [10:0] E_RST   = B_PC_INIT | E_ALLFL;
   localparam logic [10:0] E_LU    = B_PC_STALL | B_IF_STALL | B_ID_FLUSH;
   localparam logic [10:0] E_RD    = B_IF_FLUSH | B_ID_FLUSH | B_EX_FLUSH;
   localparam logic [10:0] E_MDST  = B_PC_STALL | B_IF_STALL | B_ID_STALL | B_EX_FLUSH;
   localparam logic [10:0] E_MDBSY = E_MDST | B_BUSY;
   localparam logic [10:0] E_MDDN  = B_BUSY | B_DONE;
   localparam logic [10:0] E_DBG   = B_PC_STALL | E_ALLFL;
   localparam logic [10:0] E_RES   = B_PC_INIT | E_ALLFL;

   logic [10:0] obs;
   assign obs = {pc_stall, pc_init, if_id_stall, id_ex_stall, ex_me_stall,
                 if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush,
                 muldiv_busy, muldiv_done};

   pipe_ctrl #(.MULDIV_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .debug(debug),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
      .EX_mem_read(EX_mem_read), .EX_rf_waddr(EX_rf_waddr), .EX_muldiv(EX_muldiv),
      .ME_pc_control(ME_pc_control),
      .pc_stall(pc_stall), .pc_init(pc_init),
      .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall), .ex_me_stall(ex_me_stall),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_me_flush(ex_me_flush), .me_wb_flush(me_wb_flush),
      .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
   );

   always #5 clk = ~clk;

   // check the current cycle at the falling edge, then advance past the next rising edge
   task automatic cyc(input string tag, input logic [10:0] exp);
      @(negedge clk);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      debug = 0; ID_rs = 0; ID_rt = 0; ID_use_rs = 0; ID_use_rt = 0;
      EX_mem_read = 0; EX_rf_waddr = 0; EX_muldiv = 0; ME_pc_control = 0;
   endtask

   initial begin
      reset = 1;
      quiet();
      cyc("reset0", E_RST);
      cyc("reset1", E_RST);
      cyc("reset2", E_RST);
      reset = 0;
      cyc("first_run", E_QUIET);

      EX_mem_read = 1; EX_rf_waddr = 5; ID_rs = 5; ID_use_rs = 1;
      cyc("lu_rs", E_LU);
      EX_rf_waddr = 0; ID_rs = 0;
      cyc("lu_r0", E_QUIET);
      EX_rf_waddr = 7; ID_rs = 7; ID_use_rs = 0; ID_rt = 7; ID_use_rt = 1;
      cyc("lu_rt", E_LU);
      ID_use_rt = 0;
      cyc("lu_nouse", E_QUIET);
      EX_mem_read = 0; ID_use_rt = 1;
      cyc("lu_noload", E_QUIET);

      EX_mem_read = 1; ME_pc_control = 1;
      cyc("redirect_lu", E_RD);
      quiet(); ME_pc_control = 1; EX_muldiv = 1;
      cyc("redirect_md", E_RD);
      quiet();
      cyc("redirect_md_after", E_QUIET);

      EX_muldiv = 1;
      cyc("md_c0", E_MDST);
      cyc("md_c1", E_MDBSY);
      cyc("md_c2", E_MDBSY);
      cyc("md_c3", E_MDDN);
      EX_muldiv = 0;
      cyc("md_c4", E_QUIET);

      EX_muldiv = 1;
      cyc("dbg_md_c0", E_MDST);
      cyc("dbg_md_c1", E_MDBSY);
      debug = 1;
      cyc("dbg_md_c2", E_MDBSY);
      EX_muldiv = 0;
      cyc("dbg_c3", E_DBG);
      cyc("dbg_c4", E_DBG);
      debug = 0;
      cyc("dbg_fall", E_DBG);
      cyc("resume", E_RES);
      cyc("resume_run", E_QUIET);

      EX_muldiv = 1;
      cyc("rst_md_c0", E_MDST);
      cyc("rst_md_c1", E_MDBSY);
      reset = 1;
      cyc("rst_md_reset", E_RST);
      reset = 0; EX_muldiv = 0;
      cyc("rst_md_after", E_QUIET);

      EX_muldiv = 1;
      cyc("md2_c0", E_MDST);
      cyc("md2_c1", E_MDBSY);
      cyc("md2_c2", E_MDBSY);
      cyc("md2_c3", E_MDDN);
      EX_muldiv = 0;
      cyc("md2_c4", E_QUIET);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the five-stage CPU. Generates the stall (hold) and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/ME and ME/WB wait-register banks. Resolves load-use hazards, MEM-stage branch redirects and multi-cycle mul/div occupancy, and parks the pipeline while the debug port loads instruction RAM. Sits beside the datapath: it reads decode and EX/ME status and drives the enables of every stage register.

## Interface
- MULDIV_CYCLES, 32: total EX-stage occupancy of a mul/div, in cycles; legal range 2..63.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- debug  in  1  debug/load mode; 1 = pipeline parked.
- ID_rs, ID_rt  in  5 each  source register numbers of the instruction in ID.
- ID_use_rs, ID_use_rt  in  1 each  ID instruction reads rs / rt.
- EX_mem_read  in  1  EX instruction is a load.
- EX_rf_waddr  in  5  destination register of the EX instruction.
- EX_muldiv  in  1  EX instruction is MULT/MULTU/DIV/DIVU.
- ME_pc_control  in  1  branch/jump taken, resolved in MEM.
- pc_stall  out  1  hold the PC.
- pc_init  out  1  force the PC to its reset vector.
- if_id_stall, id_ex_stall, ex_me_stall  out  1 each  hold the named register bank.
- if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush  out  1 each  load a bubble (all-zero NOP) into the named bank.
- muldiv_busy  out  1  mul/div sequencing in progress.
- muldiv_done  out  1  one-cycle pulse on the final mul/div cycle.

## Operation
- FSM states: RUN, MULDIV, DEBUG, RESUME. State and a 6-bit down-counter `cnt` are registered. All outputs are combinational from state, `cnt` and the inputs.
- Flush beats stall on the same bank. A bank is never both stalled and flushed in the same cycle.
- reset=1 (overrides everything):
  - Next state RUN, cnt=0.
  - Outputs during reset: all four flushes=1, pc_init=1, all stalls=0, muldiv_busy=0, muldiv_done=0.
- debug=1 in any state, reset=0:
  - Next state DEBUG. A mul/div in progress is abandoned and cnt is cleared.
- DEBUG:
  - pc_stall=1, all flushes=1, bank stalls=0.
  - When debug falls, next state RESUME.
- RESUME (exactly one cycle):
  - pc_init=1, all flushes=1.
  - Next state RUN.
- RUN, evaluated in this priority order:
  1. Redirect, when ME_pc_control=1:
     - if_id_flush, id_ex_flush and ex_me_flush = 1. The PC takes its new target, so pc_stall=0.
     - Any load-use hazard or EX_muldiv in the same cycle is ignored, because those instructions are being killed.
  2. Mul/div start, when EX_muldiv=1:
     - pc_stall, if_id_stall and id_ex_stall = 1; ex_me_flush=1.
     - Next state MULDIV, cnt=MULDIV_CYCLES-2.
  3. Load-use, when EX_mem_read=1, EX_rf_waddr≠0 and ((ID_use_rs and ID_rs==EX_rf_waddr) or (ID_use_rt and ID_rt==EX_rf_waddr)):
     - pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble).
  4. Otherwise every control is 0.
- MULDIV:
  - muldiv_busy=1, plus the same stall/flush pattern as the start cycle.
  - cnt decrements each cycle.
  - When cnt==0: muldiv_done=1, all stalls=0, ex_me_flush=0 (the result advances), next state RUN.
  - ME_pc_control is not sampled in MULDIV. ME holds a bubble throughout, so it cannot be 1.
- A mul/div instruction occupies EX for exactly MULDIV_CYCLES cycles, counting the start cycle.
- A register number of $0 never creates a hazard.

## Timing
- Load-use costs exactly 1 bubble. Redirect costs 3 flushed slots. Mul/div adds MULDIV_CYCLES-1 stall cycles.
- Leaving debug: debug falls at edge N → RESUME during cycle N → RUN at N+1. The first fetch from the reset vector is in cycle N+1.
- The state and cnt update on the rising edge. Outputs respond combinationally to the inputs of the current cycle, with no added latency.
- muldiv_busy is high for MULDIV_CYCLES-1 cycles; the start cycle, in RUN, is not counted.
- muldiv_done is high for exactly 1 cycle per completed mul/div. It never fires for a mul/div aborted by debug or reset.

## Test plan
- Reset held 3 cycles, then released: all flushes=1 and pc_init=1 during reset. In the first RUN cycle with quiet inputs, every output is 0.
- Load-use: EX_mem_read=1, EX_rf_waddr=5, ID_rs=5, ID_use_rs=1 → one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1. Repeat with EX_rf_waddr=0 and ID_rs=0 → no stall.
- Redirect while a load-use hazard is present: ME_pc_control=1 → if_id/id_ex/ex_me flush=1 and pc_stall=0. Same when EX_muldiv=1: the FSM stays in RUN.
- Mul/div with MULDIV_CYCLES=4:
  - EX_muldiv=1 at cycle 0 → stalls asserted in cycles 0-2.
  - muldiv_busy=1 in cycles 1-3.
  - muldiv_done=1 only in cycle 3, with stalls=0 in cycle 3; RUN in cycle 4.
- debug raised mid-mul/div (cycle 2 of 4) → DEBUG next cycle, with pc_stall=1 and all flushes=1. debug lowered → exactly one pc_init cycle, then RUN; muldiv_done never pulses.
- Reset asserted during MULDIV → next cycle in RUN with cnt=0 and muldiv_busy=0.
